// File: rtl/player_life_controller.sv
`default_nettype none
// ============================================================================
// Module   : player_life_controller
// Brief    : Player life-cycle sequencer (ALIVE/DYING/SHIELD/GAME_OVER),
//            hit arbitration, lives bookkeeping. Optional extra-life awards
//            enabled by defining PLAYER_LIFE_EXTRA_EN.
// Revision : 1.0 - initial release
// ============================================================================
module player_life_controller #(
  parameter int INIT_LIVES    = 3,
  parameter int MAX_LIVES     = 3,
  parameter int HIT_SOURCES   = 4,
  parameter int DEATH_FRAMES  = 60,
  parameter int SHIELD_FRAMES = 90
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             startOfFrame,
  input  logic [HIT_SOURCES-1:0]           hit_req,
  input  logic                             new_game,
  input  logic                             extra_life,
  output logic [HIT_SOURCES-1:0]           hit_ack,
  output logic                             player_died,
  output logic                             respawn,
  output logic                             freeze_player,
  output logic                             invulnerable,
  output logic [$clog2(MAX_LIVES+1)-1:0]   lives_left,
  output logic                             game_over
);

  localparam int c_LW         = $clog2(MAX_LIVES + 1);
  localparam int c_MAX_FRAMES = (DEATH_FRAMES > SHIELD_FRAMES) ? DEATH_FRAMES : SHIELD_FRAMES;
  localparam int c_CW         = (c_MAX_FRAMES > 1) ? $clog2(c_MAX_FRAMES) : 1;

  localparam logic [c_LW-1:0] c_INIT_LIVES  = c_LW'(INIT_LIVES);
  localparam logic [c_LW-1:0] c_MAX_LIVES   = c_LW'(MAX_LIVES);
  localparam logic [c_CW-1:0] c_DEATH_LAST  = c_CW'(DEATH_FRAMES - 1);
  localparam logic [c_CW-1:0] c_SHIELD_LAST = c_CW'(SHIELD_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_DYING     = 2'd1,
    ST_SHIELD    = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_CW-1:0]        r_frame_cnt;
  logic [c_CW-1:0]        w_frame_cnt_nxt;
  logic [c_LW-1:0]        r_lives;
  logic [c_LW-1:0]        w_lives_nxt;
  logic [c_LW-1:0]        w_lives_award;
  logic [HIT_SOURCES-1:0] w_grant;
  logic [HIT_SOURCES-1:0] w_hit_ack_nxt;
  logic                   w_died_nxt;
  logic                   w_respawn_nxt;
  logic                   w_award;

  // Isolate the lowest set request bit: bit 0 has the highest priority.
  assign w_grant = hit_req & (~hit_req + HIT_SOURCES'(1));

`ifdef PLAYER_LIFE_EXTRA_EN
  assign w_award = extra_life;
`else
  logic w_unused_extra_life;
  assign w_unused_extra_life = extra_life;
  assign w_award             = 1'b0;
`endif

  assign w_lives_award = (w_award && (r_lives < c_MAX_LIVES)) ? r_lives + c_LW'(1) : r_lives;

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_lives_nxt     = r_lives;
    w_hit_ack_nxt   = '0;
    w_died_nxt      = 1'b0;
    w_respawn_nxt   = 1'b0;

    if (new_game) begin
      w_state_nxt     = ST_ALIVE;
      w_frame_cnt_nxt = '0;
      w_lives_nxt     = c_INIT_LIVES;
    end else begin
      case (r_state)
        ST_ALIVE: begin
          w_lives_nxt = w_lives_award;
          if ((|hit_req) && (w_lives_award != '0)) begin
            w_hit_ack_nxt   = w_grant;
            w_died_nxt      = 1'b1;
            w_lives_nxt     = w_lives_award - c_LW'(1);
            w_state_nxt     = ST_DYING;
            w_frame_cnt_nxt = '0;
          end
        end

        ST_DYING: begin
          w_lives_nxt = w_lives_award;
          if (startOfFrame) begin
            if (r_frame_cnt == c_DEATH_LAST) begin
              w_frame_cnt_nxt = '0;
              // A same-cycle award still rescues the player from game over.
              if (w_lives_award == '0) begin
                w_state_nxt = ST_GAME_OVER;
              end else begin
                w_state_nxt   = ST_SHIELD;
                w_respawn_nxt = 1'b1;
              end
            end else begin
              w_frame_cnt_nxt = r_frame_cnt + c_CW'(1);
            end
          end
        end

        ST_SHIELD: begin
          w_lives_nxt = w_lives_award;
          if (startOfFrame) begin
            if (r_frame_cnt == c_SHIELD_LAST) begin
              w_frame_cnt_nxt = '0;
              w_state_nxt     = ST_ALIVE;
            end else begin
              w_frame_cnt_nxt = r_frame_cnt + c_CW'(1);
            end
          end
        end

        ST_GAME_OVER: begin
          w_state_nxt = ST_GAME_OVER;
        end

        default: begin
          w_state_nxt     = ST_ALIVE;
          w_frame_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_ALIVE;
      r_frame_cnt   <= '0;
      r_lives       <= c_INIT_LIVES;
      hit_ack       <= '0;
      player_died   <= 1'b0;
      respawn       <= 1'b0;
      freeze_player <= 1'b0;
      invulnerable  <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_lives       <= w_lives_nxt;
      hit_ack       <= w_hit_ack_nxt;
      player_died   <= w_died_nxt;
      respawn       <= w_respawn_nxt;
      freeze_player <= (w_state_nxt == ST_DYING) || (w_state_nxt == ST_GAME_OVER);
      invulnerable  <= (w_state_nxt == ST_SHIELD);
      game_over     <= (w_state_nxt == ST_GAME_OVER);
    end
  end

  assign lives_left = r_lives;

endmodule
`default_nettype wire

// File: tb/tb_player_life_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_life_controller
// Brief    : Directed self-checking bench for player_life_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_life_controller;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic [3:0] hit_req;
  logic       new_game;
  logic       extra_life;
  logic [3:0] hit_ack;
  logic       player_died;
  logic       respawn;
  logic       freeze_player;
  logic       invulnerable;
  logic [1:0] lives_left;
  logic       game_over;

  int n_checks = 0;
  int n_errors = 0;
  int died_cnt = 0;
  int respawn_cnt = 0;
  int ack_cnt = 0;
  int snap_died;
  int snap_respawn;
  int snap_ack;

  player_life_controller #(
    .INIT_LIVES   (3),
    .MAX_LIVES    (3),
    .HIT_SOURCES  (4),
    .DEATH_FRAMES (60),
    .SHIELD_FRAMES(90)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .hit_req      (hit_req),
    .new_game     (new_game),
    .extra_life   (extra_life),
    .hit_ack      (hit_ack),
    .player_died  (player_died),
    .respawn      (respawn),
    .freeze_player(freeze_player),
    .invulnerable (invulnerable),
    .lives_left   (lives_left),
    .game_over    (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      died_cnt    += int'(player_died);
      respawn_cnt += int'(respawn);
      ack_cnt     += int'(hit_ack != 4'b0000);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
    end
  endtask

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    hit_req      = 4'b0000;
    new_game     = 1'b0;
    extra_life   = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_lives",   int'(lives_left),    3);
    chk("rst_ack",     int'(hit_ack),       0);
    chk("rst_died",    int'(player_died),   0);
    chk("rst_respawn", int'(respawn),       0);
    chk("rst_freeze",  int'(freeze_player), 0);
    chk("rst_invul",   int'(invulnerable),  0);
    chk("rst_gameover", int'(game_over),    0);
    reset = 1'b0;
    step();

    // Single hit; the frame pulse on the hit cycle is not counted
    hit_req      = 4'b0100;
    startOfFrame = 1'b1;
    step();
    chk("hit1_ack",    int'(hit_ack),       4);
    chk("hit1_died",   int'(player_died),   1);
    chk("hit1_lives",  int'(lives_left),    2);
    chk("hit1_freeze", int'(freeze_player), 1);
    hit_req      = 4'b0000;
    startOfFrame = 1'b0;
    step();
    chk("hit1_ack_off",  int'(hit_ack),     0);
    chk("hit1_died_off", int'(player_died), 0);
    frames(59);
    chk("dying59_respawn", int'(respawn),       0);
    chk("dying59_freeze",  int'(freeze_player), 1);
    startOfFrame = 1'b1;
    step();
    chk("dying60_respawn", int'(respawn),       1);
    chk("dying60_invul",   int'(invulnerable),  1);
    chk("dying60_freeze",  int'(freeze_player), 0);
    startOfFrame = 1'b0;
    step();
    chk("shield_respawn_off", int'(respawn),      0);
    frames(89);
    chk("shield89_invul", int'(invulnerable), 1);
    startOfFrame = 1'b1;
    step();
    chk("shield90_invul", int'(invulnerable), 0);
    chk("shield90_lives", int'(lives_left),   2);
    startOfFrame = 1'b0;
    step();

    // Priority: lowest index wins, one pulse
    hit_req = 4'b1010;
    step();
    chk("prio_ack",   int'(hit_ack),     2);
    chk("prio_died",  int'(player_died), 1);
    chk("prio_lives", int'(lives_left),  1);
    hit_req = 4'b0001;
    step();
    chk("prio_died_once", int'(player_died), 0);

    // Shield immunity with hit held high
    frames(1);
    snap_died = died_cnt;
    snap_ack  = ack_cnt;
    frames(58);
    startOfFrame = 1'b1;
    step();
    chk("imm_respawn", int'(respawn), 1);
    startOfFrame = 1'b0;
    step();
    frames(89);
    startOfFrame = 1'b1;
    step();
    chk("imm_invul_off", int'(invulnerable), 0);
    chk("imm_no_died",   died_cnt, snap_died);
    chk("imm_no_ack",    ack_cnt,  snap_ack);
    startOfFrame = 1'b0;
    step();
    chk("imm_reaccept_ack",   int'(hit_ack),     1);
    chk("imm_reaccept_died",  int'(player_died), 1);
    chk("imm_reaccept_lives", int'(lives_left),  0);
    hit_req = 4'b0000;

    // Third death with zero lives leads to game over
    snap_respawn = respawn_cnt;
    frames(60);
    chk("go_flag",       int'(game_over),     1);
    chk("go_freeze",     int'(freeze_player), 1);
    chk("go_lives",      int'(lives_left),    0);
    chk("go_no_respawn", respawn_cnt,         snap_respawn);
    hit_req    = 4'b1111;
    extra_life = 1'b1;
    step();
    step();
    chk("go_ignore_ack",   int'(hit_ack),    0);
    chk("go_ignore_lives", int'(lives_left), 0);
    chk("go_sticky",       int'(game_over),  1);
    hit_req    = 4'b0000;
    extra_life = 1'b0;
    new_game   = 1'b1;
    step();
    new_game = 1'b0;
    chk("ng_lives",    int'(lives_left),    3);
    chk("ng_gameover", int'(game_over),     0);
    chk("ng_freeze",   int'(freeze_player), 0);
    step();

    // Hit and extra life together at full lives
    hit_req    = 4'b0001;
    extra_life = 1'b1;
    step();
    hit_req    = 4'b0000;
    extra_life = 1'b0;
    chk("sim_lives", int'(lives_left), 2);
    chk("sim_ack",   int'(hit_ack),    1);
    extra_life = 1'b1;
    step();
    extra_life = 1'b0;
`ifdef PLAYER_LIFE_EXTRA_EN
    chk("award_dying", int'(lives_left), 3);
`else
    chk("award_dying", int'(lives_left), 2);
`endif
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    chk("ng_dying_lives",  int'(lives_left),    3);
    chk("ng_dying_freeze", int'(freeze_player), 0);
    step();

    // new_game together with a hit drops the hit
    new_game = 1'b1;
    hit_req  = 4'b0010;
    step();
    new_game = 1'b0;
    hit_req  = 4'b0000;
    chk("nghit_lives",  int'(lives_left),    3);
    chk("nghit_ack",    int'(hit_ack),       0);
    chk("nghit_died",   int'(player_died),   0);
    chk("nghit_freeze", int'(freeze_player), 0);
    step();

    // Asynchronous reset mid-DYING
    hit_req = 4'b0001;
    step();
    hit_req = 4'b0000;
    chk("rmid_lives_hit", int'(lives_left), 2);
    frames(30);
    #2;
    reset = 1'b1;
    #1;
    chk("rmid_freeze", int'(freeze_player), 0);
    chk("rmid_lives",  int'(lives_left),    3);
    chk("rmid_invul",  int'(invulnerable),  0);
    step();
    reset = 1'b0;
    snap_respawn = respawn_cnt;
    frames(70);
    chk("rmid_no_respawn", respawn_cnt,          snap_respawn);
    chk("rmid_freeze_end", int'(freeze_player),  0);
    chk("rmid_invul_end",  int'(invulnerable),   0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_life_controller.md
Name: player_life_controller

Overview:
- Sequences the player's life cycle: hit → death animation → invulnerable respawn → alive, or hit → game over.
- Arbitrates hit requests from several hazard sources (monsters, falling gold bags).
- Emits the one-cycle player_died pulse that drives the life display block.
- Owns the authoritative lives count and the game-over flag consumed by the top-level game FSM.

Parameters:
- INIT_LIVES, 3: lives loaded at reset and at new_game.
- MAX_LIVES, 3: saturation limit for lives_left. Matches the 3-icon life display.
- HIT_SOURCES, 4: number of hit requesters.
- DEATH_FRAMES, 60: frames spent in DYING.
- SHIELD_FRAMES, 90: frames spent invulnerable after respawn.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- hit_req  in  HIT_SOURCES  level requests, one bit per hazard; bit 0 has highest priority.
- new_game  in  1  one-cycle pulse; restarts the life sequence.
- extra_life  in  1  one-cycle pulse from scoring; awards a life.
- hit_ack  out  HIT_SOURCES  one-hot, one-cycle grant to the accepted hazard.
- player_died  out  1  one-cycle pulse per accepted hit.
- respawn  out  1  one-cycle pulse when the player re-enters play.
- freeze_player  out  1  high in DYING and GAME_OVER.
- invulnerable  out  1  high in SHIELD.
- lives_left  out  $clog2(MAX_LIVES+1)  current lives.
- game_over  out  1  high in GAME_OVER.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - state = ALIVE; lives_left = INIT_LIVES; frame counter = 0.
  - hit_ack, player_died, respawn, freeze_player, invulnerable, game_over = 0.
- All outputs are registered.
- States: ALIVE, DYING, SHIELD, GAME_OVER.
- Frame counter:
  - Cleared on every state transition.
  - Increments only on startOfFrame while in DYING or SHIELD.
  - A startOfFrame on the transition cycle itself is not counted.
- ALIVE:
  - If any hit_req bit is set, the lowest set index wins.
  - On the next edge: hit_ack[idx] = 1 and player_died = 1 for exactly one cycle, lives_left decrements by 1, state → DYING.
  - Latency from request to pulse: 1 cycle.
- DYING:
  - hit_req is ignored and hit_ack stays 0.
  - When counter == DEATH_FRAMES-1 and startOfFrame is high (i.e. on the DEATH_FRAMES-th pulse): if lives_left == 0, go to GAME_OVER; otherwise go to SHIELD with respawn = 1 for one cycle.
- SHIELD:
  - Hits are ignored.
  - On the SHIELD_FRAMES-th startOfFrame pulse, go to ALIVE.
  - A hit_req held high at that moment is accepted on the first ALIVE cycle.
- GAME_OVER:
  - Absorbing state. Exits only via new_game or reset.
  - extra_life is ignored.
- new_game:
  - Highest priority in any state.
  - Next edge: lives_left = INIT_LIVES, state = ALIVE, counter cleared, all pulses 0.
  - Any hit in the same cycle is dropped, with no ack.
- Arithmetic:
  - lives_left never underflows; a hit is only accepted in ALIVE, and lives_left ≥ 1 there.
  - Increments saturate at MAX_LIVES.
- Hit and extra_life in the same cycle (ALIVE): the increment is applied first (saturating), then the decrement.
  - lives 2 → 2.
  - lives 3 with MAX_LIVES = 3 → 2.
- Asynchronous reset mid-DYING or mid-SHIELD returns immediately to the reset values; no respawn pulse is produced.

Optional Feature:
- Macro: PLAYER_LIFE_EXTRA_EN.
- When defined: extra_life increments lives_left (saturating at MAX_LIVES) in ALIVE, DYING and SHIELD.
  - An award arriving in DYING after lives reached 0 raises lives_left to 1, and DYING then exits to SHIELD instead of GAME_OVER.
- When undefined: the extra_life port remains but is ignored, and lives only ever decrease until new_game.

Test Plan:
- Single hit: reset, hit_req = 4'b0100 for 1 cycle → next cycle hit_ack = 4'b0100, player_died = 1 for 1 cycle; lives_left 3→2; freeze_player = 1; after exactly 60 startOfFrame pulses, respawn = 1 for 1 cycle, invulnerable = 1; after 90 more pulses, ALIVE.
- Priority: hit_req = 4'b1010 in ALIVE → hit_ack = 4'b0010 only; exactly one player_died pulse.
- Shield immunity: hit_req held at 4'b0001 throughout DYING and SHIELD → no further ack; on the first ALIVE cycle the hit is accepted again and lives_left decrements.
- Game over: 3 accepted hits from INIT_LIVES = 3 → after the third DYING, game_over = 1 and lives_left = 0; further hits and extra_life are ignored; new_game pulse → lives_left = 3, state ALIVE, game_over = 0.
- Simultaneous events: with lives_left = 3, hit and extra_life in the same cycle → lives_left = 2 (macro defined). new_game together with hit → lives_left = 3 and no hit_ack.
- Reset mid-sequence: assert reset after 30 frames in DYING → outputs return to reset values immediately; no respawn pulse after release.
